// File: rtl/led_matrix_scanner_if.sv
// Frame transfer channel between the game logic (master) and the LED matrix scanner (slave).
interface led_matrix_scanner_if;
    logic [63:0] led_array_flat;
    logic        frame_valid;
    logic        frame_ready;

    modport master (output led_array_flat, output frame_valid, input frame_ready);
    modport slave  (input led_array_flat, input frame_valid, output frame_ready);
endinterface

// File: rtl/led_matrix_scanner.sv
// Row-scan controller for an 8x8 LED matrix with a pending/display double buffer.
// Optional macro SCAN_BRIGHTNESS_EN adds a 3-bit brightness input that shortens column on-time.
//
// state | meaning
// IDLE  | scanning disabled, all LEDs off
// BLANK | all LEDs off between rows (anti-ghosting gap)
// DRIVE | one row selected, its column data on the anodes
module led_matrix_scanner #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clka,
    input  logic       restart,
    input  logic       enable,
`ifdef SCAN_BRIGHTNESS_EN
    input  logic [2:0] brightness,
`endif
    led_matrix_scanner_if.slave frame,
    output logic [7:0] row_cathode,
    output logic [7:0] column_anode,
    output logic [2:0] row_index,
    output logic       frame_done
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    row_nxt;
    logic [7:0]    cathode_nxt, anode_nxt;
    logic          done_nxt;
    logic          boundary;
    logic [63:0]   display, pending;
    logic          pending_full;
    logic          transfer;
    logic [7:0]    row_data, row_sel;

    assign row_data = display[{row_index, 3'b000} +: 8];
    assign row_sel  = ~(8'h01 << row_index);

    // The pending slot frees on the boundary edge, so a waiting frame can land in the same edge.
    assign frame.frame_ready = !pending_full || boundary;
    assign transfer          = frame.frame_valid && frame.frame_ready;

`ifdef SCAN_BRIGHTNESS_EN
    logic [CW-1:0] thr, thr_nxt, thr_entry;
    int            on_cycles;

    // Anodes stay lit while the dwell counter is at or above thr.
    assign on_cycles = ((int'(brightness) + 1) * DWELL_CYCLES) / 8;
    assign thr_entry = CW'(DWELL_CYCLES - on_cycles);
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        row_nxt     = row_index;
        cathode_nxt = 8'hFF;
        anode_nxt   = 8'h00;
        done_nxt    = 1'b0;
        boundary    = 1'b0;
`ifdef SCAN_BRIGHTNESS_EN
        thr_nxt     = thr;
`endif
        if (!enable) begin
            state_nxt = IDLE;
            row_nxt   = 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    row_nxt   = 3'd0;
                    cnt_nxt   = BLANK_LOAD;
                    boundary  = 1'b1;
                end
                BLANK: begin
                    if (cnt == '0) begin
                        state_nxt   = DRIVE;
                        cnt_nxt     = DWELL_LOAD;
                        cathode_nxt = row_sel;
                        anode_nxt   = row_data;
`ifdef SCAN_BRIGHTNESS_EN
                        thr_nxt     = thr_entry;
`endif
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        state_nxt = BLANK;
                        cnt_nxt   = BLANK_LOAD;
                        row_nxt   = row_index + 3'd1;
                        if (row_index == 3'd7) begin
                            done_nxt = 1'b1;
                            boundary = 1'b1;
                        end
                    end else begin
                        cnt_nxt     = cnt - CW'(1);
                        cathode_nxt = row_sel;
`ifdef SCAN_BRIGHTNESS_EN
                        anode_nxt   = (cnt_nxt >= thr) ? row_data : 8'h00;
`else
                        anode_nxt   = row_data;
`endif
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    row_nxt   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clka or negedge restart) begin
        if (!restart) begin
            state        <= IDLE;
            cnt          <= '0;
            row_index    <= 3'd0;
            row_cathode  <= 8'hFF;
            column_anode <= 8'h00;
            frame_done   <= 1'b0;
`ifdef SCAN_BRIGHTNESS_EN
            thr          <= '0;
`endif
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            row_index    <= row_nxt;
            row_cathode  <= cathode_nxt;
            column_anode <= anode_nxt;
            frame_done   <= done_nxt;
`ifdef SCAN_BRIGHTNESS_EN
            thr          <= thr_nxt;
`endif
        end
    end

    always_ff @(posedge clka or negedge restart) begin
        if (!restart) begin
            display      <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else begin
            if (boundary && pending_full) begin
                display <= pending;
            end
            if (transfer) begin
                pending      <= frame.led_array_flat;
                pending_full <= 1'b1;
            end else if (boundary) begin
                pending_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner: expected rows are queued as frames are scheduled,
// and a monitor compares each row as it starts being driven.
module tb_led_matrix_scanner;

    localparam int DWELL = 8;
    localparam int BLANK = 2;

    logic       clka    = 1'b0;
    logic       restart = 1'b0;
    logic       enable  = 1'b0;
    logic [7:0] row_cathode, column_anode;
    logic [2:0] row_index;
    logic       frame_done;
`ifdef SCAN_BRIGHTNESS_EN
    logic [2:0] brightness;
`endif

    led_matrix_scanner_if frame ();

    led_matrix_scanner #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
        .clka         (clka),
        .restart      (restart),
        .enable       (enable),
`ifdef SCAN_BRIGHTNESS_EN
        .brightness   (brightness),
`endif
        .frame        (frame),
        .row_cathode  (row_cathode),
        .column_anode (column_anode),
        .row_index    (row_index),
        .frame_done   (frame_done)
    );

    always #5 clka = ~clka;

    typedef struct packed {
        logic [2:0] row;
        logic [7:0] cath;
        logic [7:0] anode;
    } row_t;

    row_t exp_q[$];
    row_t mon_e;
    logic prev_off = 1'b1;
    int   checks_total  = 0;
    int   checks_passed = 0;

    logic [63:0] f_diag = 64'h8040201008040201;
    logic [63:0] f_a    = 64'h0123456789ABCDEF;
    logic [63:0] f_b    = 64'hFEDCBA9876543210;
    logic [63:0] f_c    = 64'hA5A55A5AF0F00F0F;
    logic [63:0] f_d    = 64'h1122334455667788;
    logic [63:0] f_e    = 64'hC3C3C3C3C3C3C3C3;
    logic [7:0]  diag_anode [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0]  diag_cath  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic push_rows(input logic [63:0] f, input int n);
        for (int r = 0; r < n; r++) begin
            row_t e;
            e.row   = 3'(r);
            e.cath  = ~(8'h01 << r);
            e.anode = f[r*8 +: 8];
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [63:0] f);
        frame.led_array_flat = f;
        frame.frame_valid    = 1'b1;
        tick();
        frame.frame_valid    = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cycles);
        int n = 0;
        do begin
            tick();
            n++;
        end while (frame_done !== 1'b1 && n < 400);
        checks_total++;
        if (frame_done === 1'b1) checks_passed++;
        else $display("FAIL %s: frame_done not seen within %0d cycles", name, n);
        if (exp_cycles >= 0) check({name, "_cycles"}, 64'(n), 64'(exp_cycles));
    endtask

    task automatic wait_row(input int r);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(row_index == 3'(r) && row_cathode !== 8'hFF) && n < 200);
        checks_total++;
        if (row_index == 3'(r) && row_cathode !== 8'hFF) checks_passed++;
        else $display("FAIL wait_row%0d: row not driven within %0d cycles", r, n);
    endtask

    // Monitor: compare every row at the first cycle it is driven.
    always @(negedge clka) begin
        if (restart) begin
            if (row_cathode !== 8'hFF && prev_off) begin
                if (exp_q.size() == 0) begin
                    checks_total++;
                    $display("FAIL row_scan: unexpected row %0d cathode %h anode %h, none queued",
                             row_index, row_cathode, column_anode);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("row_scan", 64'({row_index, row_cathode, column_anode}), 64'(mon_e));
                end
            end
            prev_off = (row_cathode === 8'hFF);
        end else begin
            prev_off = 1'b1;
        end
    end

    initial begin
        frame.led_array_flat = '0;
        frame.frame_valid    = 1'b0;
`ifdef SCAN_BRIGHTNESS_EN
        brightness = 3'd7;
`endif
        #12;
        check("rst_cathode", row_cathode, 8'hFF);
        check("rst_anode", column_anode, 8'h00);
        check("rst_row", row_index, 3'd0);
        check("rst_done", frame_done, 1'b0);
        check("rst_ready", frame.frame_ready, 1'b1);
        #10 restart = 1'b1;
        tick();

        // Empty display: 3 cycles off, then row 0 with zero data for the whole dwell.
        push_rows(64'h0, 8);
        enable = 1'b1;
        tick();
        check("lat_off0", row_cathode, 8'hFF);
        tick();
        check("lat_off1", row_cathode, 8'hFF);
        tick();
        check("first_cathode", row_cathode, 8'hFE);
        check("first_anode", column_anode, 8'h00);
        for (int i = 0; i < DWELL - 1; i++) begin
            tick();
            check("dwell_cathode", row_cathode, 8'hFE);
        end
        tick();
        check("blank_after_dwell", row_cathode, 8'hFF);
        wait_done("pass0", 70);
        enable = 1'b0;
        tick();
        check("idle_done", frame_done, 1'b0);
        check("idle_cathode", row_cathode, 8'hFF);

        // Diagonal frame loaded while idle shows on the next enable.
        send_frame(f_diag);
        check("diag_ready_low", frame.frame_ready, 1'b0);
        for (int r = 0; r < 8; r++) begin
            row_t e;
            e.row   = 3'(r);
            e.cath  = diag_cath[r];
            e.anode = diag_anode[r];
            exp_q.push_back(e);
        end
        enable = 1'b1;
        wait_done("diag_pass", 81);
        check("diag_row_wrap", row_index, 3'd0);
        check("diag_ready_high", frame.frame_ready, 1'b1);
        tick();
        check("done_one_cycle", frame_done, 1'b0);
        enable = 1'b0;
        tick();

        // Frame A mid-scan, B held: current pass stays diag, then A, then B.
        push_rows(f_diag, 8);
        enable = 1'b1;
        wait_row(3);
        frame.led_array_flat = f_a;
        frame.frame_valid    = 1'b1;
        tick();
        frame.led_array_flat = f_b;
        check("b_stalled", frame.frame_ready, 1'b0);
        push_rows(f_a, 8);
        push_rows(f_b, 8);
        repeat (3) tick();
        check("b_still_stalled", frame.frame_ready, 1'b0);
        wait_done("pass_diag2", -1);
        check("b_in_pending", frame.frame_ready, 1'b0);
        frame.frame_valid = 1'b0;
        wait_done("pass_a", -1);
        check("pending_empty_after_b", frame.frame_ready, 1'b1);

        // C pending at the boundary while D arrives on the boundary edge.
        wait_row(2);
        send_frame(f_c);
        check("c_pending", frame.frame_ready, 1'b0);
        push_rows(f_c, 8);
        push_rows(f_d, 6);
        wait_row(7);
        repeat (DWELL - 1) tick();
        frame.led_array_flat = f_d;
        frame.frame_valid    = 1'b1;
        tick();
        check("boundary_done", frame_done, 1'b1);
        check("boundary_ready_low", frame.frame_ready, 1'b0);
        frame.frame_valid = 1'b0;
        wait_done("pass_c", -1);
        check("d_applied_ready", frame.frame_ready, 1'b1);

        // Enable drop mid-dwell of row 5.
        wait_row(5);
        repeat (3) tick();
        enable = 1'b0;
        tick();
        check("drop_cathode", row_cathode, 8'hFF);
        check("drop_anode", column_anode, 8'h00);
        check("drop_row", row_index, 3'd0);
        check("drop_done", frame_done, 1'b0);
        tick();
        check("drop_done_later", frame_done, 1'b0);
        push_rows(f_d, 8);
        enable = 1'b1;
        wait_done("reenable_pass", 81);
        enable = 1'b0;
        tick();

        // Asynchronous restart mid-row blanks at once and discards the frames.
        push_rows(f_d, 3);
        enable = 1'b1;
        wait_row(2);
        repeat (2) tick();
        #3 restart = 1'b0;
        #1;
        check("async_cathode", row_cathode, 8'hFF);
        check("async_anode", column_anode, 8'h00);
        check("async_row", row_index, 3'd0);
        check("async_ready", frame.frame_ready, 1'b1);
        enable = 1'b0;
        @(posedge clka);
        #2 restart = 1'b1;
        tick();
        push_rows(64'h0, 8);
        enable = 1'b1;
        wait_done("post_restart_pass", 81);
        enable = 1'b0;
        tick();

`ifdef SCAN_BRIGHTNESS_EN
        send_frame(f_e);
        brightness = 3'd3;
        push_rows(f_e, 8);
        enable = 1'b1;
        tick();
        tick();
        for (int i = 0; i < DWELL; i++) begin
            tick();
            check("dim_cathode", row_cathode, 8'hFE);
            check("dim_anode", column_anode, (i < 4) ? f_e[7:0] : 8'h00);
        end
        wait_done("dim_pass", -1);
        enable = 1'b0;
        tick();
`endif

        repeat (3) tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
Time-multiplexed row-scan controller for the 8x8 LED matrix. It takes the 64-bit game-board image from the game logic and accepts whole frames through a valid/ready handshake. A one-frame pending buffer keeps each displayed frame tear-free. It cycles one active row at a time onto row_cathode/column_anode, with a blanking gap between rows to suppress ghosting.

Parameters:
DWELL_CYCLES, 1000, clka cycles each row is driven (minimum 8)
BLANK_CYCLES, 16, clka cycles all LEDs are off between rows (minimum 1)

Ports:
clka  input  1  system clock; all state changes on its rising edge
restart  input  1  asynchronous active-low reset
enable  input  1  scanning permitted; low forces all LEDs off
led_array_flat  input  64  frame image; bit r*8+c = row r, column c, 1 = lit
frame_valid  input  1  led_array_flat holds a new frame
frame_ready  output  1  pending buffer empty; transfer when frame_valid & frame_ready
row_cathode  output  8  one-cold row select; bit r low = row r driven
column_anode  output  8  active-high column data for the selected row
row_index  output  3  row currently (or next) driven
frame_done  output  1  one-cycle pulse after row 7 dwell completes

Behaviour:
- Reset (restart low, asynchronous) sets:
  - state IDLE, row_cathode 8'hFF, column_anode 8'h00, row_index 0, frame_done 0;
  - display buffer 0, pending buffer empty, frame_ready 1.
- States:
  - IDLE: outputs off. When enable=1, next edge goes to BLANK with row_index 0.
  - BLANK: outputs off for BLANK_CYCLES cycles, then DRIVE.
  - DRIVE: row_cathode = ~(1<<row_index), column_anode = display[row_index*8 +: 8] for DWELL_CYCLES cycles.
    - End of dwell for rows 0-6: row_index+1, go to BLANK.
    - End of dwell for row 7: row_index wraps to 0, frame_done pulses for exactly one cycle, go to BLANK.
- Outputs are registered and change only on state entry. Latency from the enable rise to the first lit row is 1+BLANK_CYCLES cycles.
- Dwell and blank timing uses one down-counter, wide enough for max(DWELL_CYCLES, BLANK_CYCLES), reloaded on every state entry.
- Handshake:
  - A transfer loads the pending buffer and sets it full. frame_ready is low while the buffer is full.
  - frame_valid while frame_ready=0 is ignored; the producer must hold it.
- Frame boundary (entry into BLANK with row_index 0, including from IDLE):
  - If the pending buffer is full, it copies to the display buffer and the pending buffer empties.
  - A transfer on that same edge: the old pending frame is applied, the new frame lands in pending, and frame_ready stays low.
  - A transfer when the buffer was empty at the boundary is not applied until the next boundary.
- A display frame never changes mid-scan; all 8 rows of one pass show the same image.
- enable falls in any state: next edge goes to IDLE with outputs off and row_index 0. The pending buffer is retained and no frame_done pulse is issued.
- restart low mid-row blanks the outputs immediately (asynchronous) and discards both buffers.

Optional Feature:
SCAN_BRIGHTNESS_EN
- Defined: adds input brightness[2:0]. In DRIVE, column_anode carries row data only for the first ((brightness+1)*DWELL_CYCLES)/8 cycles of the dwell and is 8'h00 for the rest. The row stays selected and total row timing is unchanged. brightness is sampled at each DRIVE entry.
- Undefined: no brightness port; column data is present for the full dwell.

Test Plan:
- Reset then enable=1 (DWELL=8, BLANK=2) -> outputs off 3 cycles, then row_cathode 8'hFE with column_anode equal to display bits [7:0] (=0) for 8 cycles.
- Load frame 64'h8040201008040201 while IDLE, then enable -> rows 0..7 show anode 8'h01,8'h02,...,8'h80; cathode 8'hFE,8'hFD,...,8'h7F; frame_done pulses once after row 7; row_index returns to 0.
- Send frame A during row 3, frame B with frame_valid held -> B stalls (frame_ready=0) until the next boundary; that whole frame shows A, the following frame shows B.
- frame_valid rising on the boundary edge with pending full -> pending applied, new frame held, frame_ready stays 0.
- Drop enable mid-dwell of row 5 -> next edge row_cathode 8'hFF, anode 8'h00, row_index 0, no frame_done; re-enable restarts at row 0.
- With SCAN_BRIGHTNESS_EN, brightness=3, DWELL=8 -> anode data for 4 cycles then 8'h00 for 4, cathode held low for all 8.
